dividend_rebuilder: RTL



---
 rtl/calc_pkg.sv | 17 +
 rtl/dividend_rebuilder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: operand width, invalid-divisor encodings and
// the dividend rebuilder's state encoding.
package calc_pkg;

    localparam int CALC_W = 3;

    localparam logic [CALC_W-1:0] DIV_ZERO    = 3'b000;
    localparam logic [CALC_W-1:0] DIV_NEG_MIN = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } rb_state_t;

endpackage

// File: rtl/dividend_rebuilder.sv
// Rebuilds A = Q*B + R with a W-cycle shift-add multiply followed by one add
// cycle; flags follow the remainder unit's SF/ZF/DZF conventions plus OVF/RVF.
module dividend_rebuilder
    import calc_pkg::*;
#(
    parameter int W = CALC_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   Q,
    input  logic [W-1:0]   B,
    input  logic [W-1:0]   R,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] A,
    output logic           SF,
    output logic           ZF,
    output logic           DZF,
    output logic           OVF,
    output logic           RVF
);

    localparam int AW = 2 * W;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    // At the calculator width the invalid divisors come from the shared package.
    localparam logic [W-1:0] INV_ZERO = '0;
    localparam logic [W-1:0] INV_NMIN = (W == CALC_W) ? W'(DIV_NEG_MIN | DIV_ZERO)
                                                      : {1'b1, {(W-1){1'b0}}};

    rb_state_t       state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [W-1:0]    q_r, q_n;
    logic [W-1:0]    b_r, b_n;
    logic [W-1:0]    r_r, r_n;
    logic [AW-1:0]   acc, acc_n;
    logic [AW-1:0]   sum;
    logic            busy_n, done_n;
    logic [AW-1:0]   a_n;
    logic            sf_n, zf_n, dzf_n, ovf_n, rvf_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        q_n     = q_r;
        b_n     = b_r;
        r_n     = r_r;
        acc_n   = acc;
        sum     = acc + AW'(r_r);
        busy_n  = busy;
        done_n  = 1'b0;
        a_n     = A;
        sf_n    = SF;
        zf_n    = ZF;
        dzf_n   = DZF;
        ovf_n   = OVF;
        rvf_n   = RVF;

        case (state)
            IDLE: begin
                if (start) begin
                    q_n = Q;
                    b_n = B;
                    r_n = R;
                    if (B == INV_ZERO || B == INV_NMIN) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        a_n     = '0;
                        sf_n    = 1'b0;
                        zf_n    = 1'b0;
                        dzf_n   = 1'b1;
                        ovf_n   = 1'b0;
                        rvf_n   = 1'b0;
                    end else begin
                        state_n = MUL;
                        busy_n  = 1'b1;
                        acc_n   = '0;
                        cnt_n   = '0;
                    end
                end
            end
            MUL: begin
                if (q_r[cnt])
                    acc_n = acc + (AW'(b_r) << cnt);
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(W - 1))
                    state_n = ADD;
            end
            ADD: begin
                acc_n   = sum;
                state_n = DONE;
                done_n  = 1'b1;
                busy_n  = 1'b0;
                a_n     = sum;
                sf_n    = sum[W-1];
                zf_n    = (sum == '0);
                dzf_n   = 1'b0;
                ovf_n   = |sum[AW-1:W];
                rvf_n   = (r_r >= b_r);
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            q_r   <= '0;
            b_r   <= '0;
            r_r   <= '0;
            acc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            A     <= '0;
            SF    <= 1'b0;
            ZF    <= 1'b0;
            DZF   <= 1'b0;
            OVF   <= 1'b0;
            RVF   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            q_r   <= q_n;
            b_r   <= b_n;
            r_r   <= r_n;
            acc   <= acc_n;
            busy  <= busy_n;
            done  <= done_n;
            A     <= a_n;
            SF    <= sf_n;
            ZF    <= zf_n;
            DZF   <= dzf_n;
            OVF   <= ovf_n;
            RVF   <= rvf_n;
        end
    end

endmodule
